// File: rtl/lis_fixed_stream_sorter_pkg.sv
// Shared types for the linear insertion stream sorter.
// Word width, byte count per word and the LOAD/DRAIN state encoding.
package lis_fixed_stream_sorter_pkg;

    localparam int WORD_W = 32;

    function automatic int bytes_per_word(input int w);
        return w / 8;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(WORD_W);

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef logic signed [WORD_W-1:0] word_t;

endpackage

// File: rtl/lis_fixed_stream_sorter_cell.sv
// One storage cell of the insertion chain.
// Holds a signed word; either shifts up from below or takes the new word.
module lis_cell #(
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] new_word,
    input  logic                     insert_here,
    input  logic                     shift_in,
    input  logic signed [DATA_W-1:0] below_value,
    input  logic                     below_valid,
    output logic signed [DATA_W-1:0] value,
    output logic                     valid,
    output logic                     gt_or_empty
);

    assign gt_or_empty = !valid || (value > new_word);

    // Cell contents: shift wins over insert, clear wipes the frame
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            value <= '0;
            valid <= 1'b0;
        end else if (shift_in) begin
            value <= below_value;
            valid <= below_valid;
        end else if (insert_here) begin
            value <= new_word;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/lis_fixed_stream_sorter.sv
// Byte-stream insertion sorter: assembles words MSB first,
// inserts them into a sorted cell chain, drains ascending.
module lis_fixed_stream_sorter
    import lis_fixed_stream_sorter_pkg::*;
#(
    parameter int LIS_SIZE = 8,
    parameter int DATA_W   = WORD_W
) (
    input  logic       clock,
    input  logic       reset,
    output logic       in_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data
);

    localparam int BPW = bytes_per_word(DATA_W);
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CW  = $clog2(LIS_SIZE + 1);
    localparam int IW  = $clog2(LIS_SIZE);

    state_t                   state_q, state_d;
    logic [BW-1:0]            wr_byte_q, wr_byte_d;
    logic [BW-1:0]            rd_byte_q, rd_byte_d;
    logic [IW-1:0]            rd_word_q, rd_word_d;
    logic [CW-1:0]            count_q, count_d;
    logic [DATA_W-9:0]        acc_q;
    logic                     in_ready_q;
    logic                     accept, word_done, out_fire;
    logic                     rd_last, clear, full;
    logic signed [DATA_W-1:0] new_word, rd_value;
    logic signed [DATA_W-1:0] cell_value [LIS_SIZE];
    logic [LIS_SIZE-1:0]      cell_valid, gt, below_gt;
    logic [LIS_SIZE-1:0]      ins, shift;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DRAIN);
    assign accept    = in_valid && in_ready_q;
    assign word_done = accept && (wr_byte_q == BW'(BPW - 1));
    assign out_fire  = out_valid && out_ready;
    assign new_word  = {acc_q, in_data};
    assign full      = cell_valid[LIS_SIZE-1];
    assign rd_last   = (CW'(rd_word_q) == count_q - CW'(1));
    assign rd_value  = cell_value[rd_word_q];

    // Priority chain: a cell is the insertion point if no lower cell is
    always_comb begin
        logic run;
        run = 1'b0;
        below_gt = '0;
        for (int i = 0; i < LIS_SIZE; i++) begin
            below_gt[i] = run;
            run = run | gt[i];
        end
    end

    assign ins   = (word_done && !full) ? (gt & ~below_gt) : '0;
    assign shift = (word_done && !full) ? below_gt : '0;

    for (genvar i = 0; i < LIS_SIZE; i++) begin : g_cell
        logic signed [DATA_W-1:0] below_value;
        logic                     below_valid;
        if (i == 0) begin : g_first
            assign below_value = '0;
            assign below_valid = 1'b0;
        end else begin : g_rest
            assign below_value = cell_value[i-1];
            assign below_valid = cell_valid[i-1];
        end
        lis_cell #(
            .DATA_W(DATA_W)
        ) u_cell (
            .clock      (clock),
            .reset      (reset),
            .clear      (clear),
            .new_word   (new_word),
            .insert_here(ins[i]),
            .shift_in   (shift[i]),
            .below_value(below_value),
            .below_valid(below_valid),
            .value      (cell_value[i]),
            .valid      (cell_valid[i]),
            .gt_or_empty(gt[i])
        );
    end

    // Drain byte select, MSB first; zero outside DRAIN
    always_comb begin
        out_data = '0;
        if (state_q == DRAIN) begin
            out_data = rd_value[8*(BPW-1-int'(rd_byte_q)) +: 8];
        end
    end

    // Next-state and counter updates for LOAD/DRAIN
    always_comb begin
        state_d   = state_q;
        wr_byte_d = wr_byte_q;
        rd_byte_d = rd_byte_q;
        rd_word_d = rd_word_q;
        count_d   = count_q;
        clear     = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (word_done) begin
                    wr_byte_d = '0;
                    count_d   = count_q + CW'(1);
                    if (in_last || count_d == CW'(LIS_SIZE)) begin
                        state_d = DRAIN;
                    end
                end else if (accept) begin
                    wr_byte_d = wr_byte_q + BW'(1);
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (rd_byte_q == BW'(BPW - 1)) begin
                        rd_byte_d = '0;
                        if (rd_last) begin
                            clear     = 1'b1;
                            rd_word_d = '0;
                            count_d   = '0;
                            state_d   = LOAD;
                        end else begin
                            rd_word_d = rd_word_q + IW'(1);
                        end
                    end else begin
                        rd_byte_d = rd_byte_q + BW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // State, counters, byte accumulator and registered in_ready
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= LOAD;
            wr_byte_q  <= '0;
            rd_byte_q  <= '0;
            rd_word_q  <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_byte_q  <= wr_byte_d;
            rd_byte_q  <= rd_byte_d;
            rd_word_q  <= rd_word_d;
            count_q    <= count_d;
            in_ready_q <= (state_d == LOAD);
            if (accept) begin
                acc_q <= new_word[DATA_W-9:0];
            end
        end
    end

endmodule

// File: tb/tb_lis_fixed_stream_sorter.sv
// Directed bench for the stream sorter, LIS_SIZE = 4.
// Inputs driven on the falling edge, outputs sampled there too.
module tb_lis_fixed_stream_sorter;
    import lis_fixed_stream_sorter_pkg::*;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_ready;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;

    int    n_checks = 0;
    int    n_fails  = 0;
    word_t tx [8];
    word_t ex [8];

    always #5 clock = ~clock;

    lis_fixed_stream_sorter #(
        .LIS_SIZE(N),
        .DATA_W  (WORD_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_ready (in_ready),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    task automatic put_byte(input logic [7:0] d, input bit last,
                            input bit gaps);
        int n;
        int g;
        if (gaps) begin
            g = $urandom_range(0, 2);
            for (int i = 0; i < g; i++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'b1;
                @(negedge clock);
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_word,
                              input int mid_last_word, input bit gaps);
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            w = tx[k];
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                put_byte(w[31-8*b -: 8],
                         (k == last_word && b == BYTES_PER_WORD - 1) ||
                         (k == mid_last_word && b == 1), gaps);
            end
        end
    endtask

    task automatic drain_check(input string name, input int n,
                               input bit rnd);
        int          total;
        int          idx;
        int          cyc;
        bit          stall;
        bit          ir_bad;
        bit          rdy;
        logic [7:0]  held;
        logic [7:0]  exp_b;
        logic [31:0] w;
        total  = n * BYTES_PER_WORD;
        idx    = 0;
        cyc    = 0;
        stall  = 1'b0;
        ir_bad = 1'b0;
        held   = 8'h00;
        while (idx < total && cyc < 1000) begin
            if (stall) begin
                n_checks++;
                if (out_data !== held || out_valid !== 1'b1) begin
                    n_fails++;
                    $display("FAIL %s_hold: out_data=%h valid=%b required %h 1",
                             name, out_data, out_valid, held);
                end
            end
            stall = 1'b0;
            rdy   = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid === 1'b1) begin
                if (in_ready !== 1'b0) ir_bad = 1'b1;
                if (rdy) begin
                    w     = ex[idx/4];
                    exp_b = w[31-8*(idx%4) -: 8];
                    n_checks++;
                    if (out_data !== exp_b) begin
                        n_fails++;
                        $display("FAIL %s_byte%0d: out_data=%h required %h",
                                 name, idx, out_data, exp_b);
                    end
                    idx++;
                end else begin
                    stall = 1'b1;
                    held  = out_data;
                end
            end
            out_ready = rdy;
            if (rnd) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            @(negedge clock);
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if (idx != total) begin
            n_fails++;
            $display("FAIL %s_count: bytes=%0d required %0d", name, idx, total);
        end
        n_checks++;
        if (ir_bad) begin
            n_fails++;
            $display("FAIL %s_in_ready_drain: in_ready=1 required 0", name);
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL %s_turnaround: out_valid=%b in_ready=%b required 0 1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic load_basic();
        tx[0] = 32'h0000_0005; tx[1] = 32'hFFFF_FFFE;
        tx[2] = 32'h0000_0003; tx[3] = 32'h0000_0005;
        ex[0] = 32'hFFFF_FFFE; ex[1] = 32'h0000_0003;
        ex[2] = 32'h0000_0005; ex[3] = 32'h0000_0005;
    endtask

    task automatic load_extremes();
        tx[0] = 32'h7FFF_FFFF; tx[1] = 32'h8000_0000;
        tx[2] = 32'h0000_0000; tx[3] = 32'hFFFF_FFFF;
        ex[0] = 32'h8000_0000; ex[1] = 32'hFFFF_FFFF;
        ex[2] = 32'h0000_0000; ex[3] = 32'h7FFF_FFFF;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%h required 0 0 00",
                     in_ready, out_valid, out_data);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_basic_sort();
        load_basic();
        send_frame(4, -1, -1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL basic_latency: out_valid=%b in_ready=%b required 1 0",
                     out_valid, in_ready);
        end
        drain_check("basic", 4, 1'b0);
    endtask

    task automatic test_extremes();
        load_extremes();
        send_frame(4, -1, -1, 1'b0);
        drain_check("extremes", 4, 1'b0);
    endtask

    task automatic test_early_end();
        tx[0] = 32'h0000_0010; tx[1] = 32'h0000_0001;
        ex[0] = 32'h0000_0001; ex[1] = 32'h0000_0010;
        send_frame(2, 1, 0, 1'b0);
        drain_check("early_end", 2, 1'b0);
    endtask

    task automatic test_backpressure();
        load_basic();
        send_frame(4, -1, -1, 1'b1);
        drain_check("backpressure", 4, 1'b1);
    endtask

    task automatic test_back_to_back();
        tx[0] = 32'h0000_0100; tx[1] = 32'h0000_0001;
        tx[2] = 32'hFFFF_FF00; tx[3] = 32'h0000_0050;
        ex[0] = 32'hFFFF_FF00; ex[1] = 32'h0000_0001;
        ex[2] = 32'h0000_0050; ex[3] = 32'h0000_0100;
        send_frame(4, -1, -1, 1'b0);
        drain_check("b2b_first", 4, 1'b0);
        tx[0] = 32'h0000_000A; tx[1] = 32'h8000_0001;
        tx[2] = 32'h0000_000A; tx[3] = 32'h0000_0002;
        ex[0] = 32'h8000_0001; ex[1] = 32'h0000_0002;
        ex[2] = 32'h0000_000A; ex[3] = 32'h0000_000A;
        send_frame(4, -1, -1, 1'b0);
        drain_check("b2b_second", 4, 1'b0);
    endtask

    task automatic test_reset_in_drain();
        logic [31:0] w;
        logic [7:0]  exp_b;
        load_basic();
        send_frame(4, -1, -1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            w     = ex[k/4];
            exp_b = w[31-8*(k%4) -: 8];
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_b) begin
                n_fails++;
                $display("FAIL rst_drain_byte%0d: valid=%b data=%h required 1 %h",
                         k, out_valid, out_data, exp_b);
            end
            out_ready = 1'b1;
            @(negedge clock);
        end
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_drain_cut: out_valid=%b out_data=%h in_ready=%b required 0 00 0",
                     out_valid, out_data, in_ready);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_drain_release: in_ready=%b out_valid=%b required 1 0",
                     in_ready, out_valid);
        end
        load_extremes();
        send_frame(4, -1, -1, 1'b0);
        drain_check("rst_fresh", 4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_sort();
        test_extremes();
        test_early_end();
        test_backpressure();
        test_back_to_back();
        test_reset_in_drain();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
